// File: rtl/led_serial_rx.sv
// led_serial_rx: deserialise the PHY sclk/sdata/sload LED stream into per-port link/act flags plus a blink wave
//   clk, rst_n           system clock, async active-low reset
//   sclk, sdata, sload   async serial LED stream from the PHY
//   link[NPORT]          1 = port down (LED dark)
//   act[NPORT]           1 = link up and idle (LED steady); link=act=0 means traffic
//   blink                free-running square wave, half-period BLINK_DIV clk cycles
//   frame_err            one-cycle pulse when a frame is rejected (short or overrun)
//   Optional macro LED_RX_TIMEOUT_EN adds a watchdog that forces all ports down after TIMEOUT idle cycles.
module led_serial_rx #(
    parameter int NPORT     = 8,
    parameter int BLINK_DIV = 2500000,
    parameter int TIMEOUT   = 25000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sclk,
    input  logic             sdata,
    input  logic             sload,
    output logic [NPORT-1:0] link,
    output logic [NPORT-1:0] act,
    output logic             blink,
    output logic             frame_err
);
    localparam int FL = 2 * NPORT;
    localparam int CW = $clog2(FL + 2);
    localparam int BW = $clog2(BLINK_DIV);

    logic [2:0]    sclk_s, sload_s, sdata_s;
    logic          sclk_re, sload_re;
    logic [FL-1:0] shreg;
    logic [CW-1:0] bitcnt;
    logic [BW-1:0] bcnt;
    logic          accept, reject, bwrap;

    assign accept = sload_re && (bitcnt == CW'(FL));
    assign reject = sload_re && !accept;
    assign bwrap  = bcnt == BW'(BLINK_DIV - 1);

    // Edge pulses are registered, so sdata is delayed one extra stage to stay aligned with them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_s   <= '0;
            sload_s  <= '0;
            sdata_s  <= '0;
            sclk_re  <= 1'b0;
            sload_re <= 1'b0;
        end else begin
            sclk_s   <= {sclk_s[1:0], sclk};
            sload_s  <= {sload_s[1:0], sload};
            sdata_s  <= {sdata_s[1:0], sdata};
            sclk_re  <= sclk_s[1] & ~sclk_s[2];
            sload_re <= sload_s[1] & ~sload_s[2];
        end
    end

    // sload wins a collision with sclk: that bit is dropped and the count restarts at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg  <= '0;
            bitcnt <= '0;
        end else if (sload_re) begin
            bitcnt <= '0;
        end else if (sclk_re) begin
            shreg  <= {shreg[FL-2:0], sdata_s[2]};
            bitcnt <= (bitcnt == CW'(FL + 1)) ? bitcnt : bitcnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt  <= '0;
            blink <= 1'b1;
        end else begin
            bcnt  <= bwrap ? '0 : bcnt + 1'b1;
            blink <= bwrap ? ~blink : blink;
        end
    end

`ifdef LED_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wd;
    logic          expire;

    // Expires on the edge the count would reach TIMEOUT, then stays saturated until a frame is accepted.
    assign expire = !accept && (wd == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wd <= '0;
        else if (accept)
            wd <= '0;
        else if (wd != TW'(TIMEOUT))
            wd <= wd + 1'b1;
    end
`else
    logic expire;
    assign expire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            link      <= '1;
            act       <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= reject;
            if (accept) begin
                link <= shreg[FL-1:NPORT];
                act  <= shreg[NPORT-1:0];
            end else if (expire) begin
                link <= '1;
                act  <= '0;
            end
        end
    end
endmodule
